seq_restoring_divider: RTL and testbench

Sequential restoring divider that reverses the shift-and-add multiplier. It receives a 16-bit dividend as two byte strobes, low byte first then high byte, the same LSB-then-MSB result sequence the multiplier controller emits. It divides by an 8-bit divisor using one shift-and-subtract step per clock. The quotient and remainder are returned on a shared byte bus, quotient first. The block sits directly downstream of the multiplier result port and is used for result checking and for division datapaths.

---
 rtl/seq_restoring_divider.sv | 173 +++++++++++++++++
 tb/tb_seq_restoring_divider.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: 16-bit dividend (low byte then high byte) / 8-bit divisor,
// one shift-and-subtract step per clock, quotient then remainder returned on a shared byte bus.
module seq_restoring_divider #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] divisor,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  lsb_in,
    input  logic                  msb_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  q_valid,
    output logic                  r_valid,
    output logic                  ovf,
    output logic                  done
);

    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_LO = 3'd1,
        WAIT_HI = 3'd2,
        CHECK   = 3'd3,
        ITER    = 3'd4,
        RSLT_Q  = 3'd5,
        RSLT_R  = 3'd6
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] d_q, d_d;
    logic [DATA_WIDTH:0]   r_q, r_d;
    logic [DATA_WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  q_valid_q, q_valid_d;
    logic                  r_valid_q, r_valid_d;
    logic [DATA_WIDTH:0]   s_s, t_s;

    // State register and datapath flops, cleared asynchronously
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            d_q        <= '0;
            r_q        <= '0;
            q_q        <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            data_out_q <= '0;
            q_valid_q  <= 1'b0;
            r_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            d_q        <= d_d;
            r_q        <= r_d;
            q_q        <= q_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            data_out_q <= data_out_d;
            q_valid_q  <= q_valid_d;
            r_valid_q  <= r_valid_d;
        end
    end

    // Next-state and datapath update logic
    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        r_d     = r_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        // Shifted partial remainder; R[7:0] < D guarantees S fits in 9 bits
        s_s     = {r_q[DATA_WIDTH-1:0], q_q[DATA_WIDTH-1]};
        t_s     = s_s - {1'b0, d_q};
        case (state_q)
            IDLE: begin
                if (start) begin
                    d_d     = divisor;
                    ovf_d   = 1'b0;
                    state_d = WAIT_LO;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_LO: begin
                if (lsb_in) begin
                    q_d     = data_in;
                    state_d = WAIT_HI;
                end else begin
                    state_d = WAIT_LO;
                end
            end
            WAIT_HI: begin
                if (msb_in) begin
                    r_d     = {1'b0, data_in};
                    state_d = CHECK;
                end else begin
                    state_d = WAIT_HI;
                end
            end
            CHECK: begin
                // High byte >= divisor means the quotient cannot fit (also catches D=0)
                if (r_q >= {1'b0, d_q}) begin
                    ovf_d   = 1'b1;
                    q_d     = {DATA_WIDTH{1'b1}};
                    r_d     = {1'b0, {DATA_WIDTH{1'b1}}};
                    state_d = RSLT_Q;
                end else begin
                    cnt_d   = '0;
                    state_d = ITER;
                end
            end
            ITER: begin
                if (s_s >= {1'b0, d_q}) begin
                    r_d = t_s;
                    q_d = {q_q[DATA_WIDTH-2:0], 1'b1};
                end else begin
                    r_d = s_s;
                    q_d = {q_q[DATA_WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                    state_d = RSLT_Q;
                end else begin
                    state_d = ITER;
                end
            end
            RSLT_Q:  state_d = RSLT_R;
            RSLT_R:  state_d = IDLE;
            default: begin
                state_d = IDLE;
                d_d     = '0;
                r_d     = '0;
                q_d     = '0;
                cnt_d   = '0;
                ovf_d   = 1'b0;
            end
        endcase
    end

    // Output registers are loaded from the upcoming state so they align with it
    always_comb begin
        data_out_d = '0;
        q_valid_d  = 1'b0;
        r_valid_d  = 1'b0;
        case (state_d)
            RSLT_Q: begin
                data_out_d = q_d;
                q_valid_d  = 1'b1;
            end
            RSLT_R: begin
                data_out_d = r_d[DATA_WIDTH-1:0];
                r_valid_d  = 1'b1;
            end
            default: begin
                data_out_d = '0;
                q_valid_d  = 1'b0;
                r_valid_d  = 1'b0;
            end
        endcase
    end

    assign data_out = data_out_q;
    assign q_valid  = q_valid_q;
    assign r_valid  = r_valid_q;
    assign ovf      = ovf_q;
    assign done     = (state_q == IDLE);

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed self-checking bench for seq_restoring_divider: arithmetic, overflow, protocol and reset.
module tb_seq_restoring_divider;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] divisor;
    logic [7:0] data_in;
    logic       lsb_in;
    logic       msb_in;
    logic [7:0] data_out;
    logic       q_valid;
    logic       r_valid;
    logic       ovf;
    logic       done;

    int checks = 0;
    int errors = 0;

    logic [7:0] qv, rv;
    logic       ov;
    int         lq, lr, ld, nq;

    seq_restoring_divider #(.DATA_WIDTH(8)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .start   (start),
        .divisor (divisor),
        .data_in (data_in),
        .lsb_in  (lsb_in),
        .msb_in  (msb_in),
        .data_out(data_out),
        .q_valid (q_valid),
        .r_valid (r_valid),
        .ovf     (ovf),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a full request; returns just after the edge that accepted msb_in (E0)
    task automatic issue(input logic [7:0] d, input logic [7:0] lo, input logic [7:0] hi, input int gap);
        @(negedge clk);
        start = 1'b1; divisor = d;
        @(negedge clk);
        start = 1'b0; lsb_in = 1'b1; data_in = lo;
        @(negedge clk);
        lsb_in = 1'b0;
        repeat (gap) @(negedge clk);
        msb_in = 1'b1; data_in = hi;
        @(negedge clk);
        msb_in = 1'b0;
    endtask

    // Observe the response; latencies are counted in edges after E0, -1 if never seen
    task automatic collect(output logic [7:0] q_o, output logic [7:0] r_o, output logic ov_o,
                           output int lq_o, output int lr_o, output int ld_o, output int nq_o);
        q_o = 8'h00; r_o = 8'h00; ov_o = 1'b0;
        lq_o = -1; lr_o = -1; ld_o = -1; nq_o = 0;
        for (int n = 1; n <= 40 && ld_o < 0; n++) begin
            @(posedge clk);
            #1;
            if (q_valid) begin
                q_o = data_out; ov_o = ovf; lq_o = n; nq_o++;
                if (r_valid) nq_o += 10;
            end
            if (r_valid) begin
                r_o = data_out; lr_o = n;
            end
            if (done && lr_o >= 0) ld_o = n;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; divisor = 8'h00; data_in = 8'h00; lsb_in = 1'b0; msb_in = 1'b0;
        #12;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL reset_done got %b exp 1", done); end
        checks++; if ({q_valid, r_valid, ovf} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {q_valid, r_valid, ovf}); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", data_out); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_exact();
        issue(8'h0D, 8'h28, 8'h0A, 0);
        collect(qv, rv, ov, lq, lr, ld, nq);
        checks++; if (qv !== 8'hC8) begin errors++; $display("FAIL exact_q got %h exp c8", qv); end
        checks++; if (rv !== 8'h00) begin errors++; $display("FAIL exact_r got %h exp 00", rv); end
        checks++; if (ov !== 1'b0) begin errors++; $display("FAIL exact_ovf got %b exp 0", ov); end
        checks++; if (lq !== 9 || lr !== 10 || ld !== 11) begin errors++; $display("FAIL exact_latency got q%0d r%0d d%0d exp q9 r10 d11", lq, lr, ld); end
        checks++; if (nq !== 1) begin errors++; $display("FAIL exact_qpulse got %0d exp 1", nq); end
    endtask

    task automatic test_remainder();
        issue(8'h56, 8'h34, 8'h12, 0);
        collect(qv, rv, ov, lq, lr, ld, nq);
        checks++; if (qv !== 8'h36 || rv !== 8'h10) begin errors++; $display("FAIL rem_qr got %h/%h exp 36/10", qv, rv); end
        checks++; if (ov !== 1'b0 || lq !== 9) begin errors++; $display("FAIL rem_ovf_lat got %b/%0d exp 0/9", ov, lq); end
    endtask

    task automatic test_max_operands();
        issue(8'hFF, 8'h01, 8'hFE, 0);
        collect(qv, rv, ov, lq, lr, ld, nq);
        checks++; if (qv !== 8'hFF || rv !== 8'h00 || ov !== 1'b0) begin errors++; $display("FAIL max_ff got %h/%h/%b exp ff/00/0", qv, rv, ov); end
        issue(8'h01, 8'hFF, 8'h00, 0);
        collect(qv, rv, ov, lq, lr, ld, nq);
        checks++; if (qv !== 8'hFF || rv !== 8'h00 || ov !== 1'b0) begin errors++; $display("FAIL max_one got %h/%h/%b exp ff/00/0", qv, rv, ov); end
    endtask

    task automatic test_overflow();
        issue(8'h12, 8'h34, 8'h12, 0);
        collect(qv, rv, ov, lq, lr, ld, nq);
        checks++; if (qv !== 8'hFF || rv !== 8'hFF) begin errors++; $display("FAIL ovf_qr got %h/%h exp ff/ff", qv, rv); end
        checks++; if (ov !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", ov); end
        checks++; if (lq !== 1 || lr !== 2 || ld !== 3) begin errors++; $display("FAIL ovf_latency got q%0d r%0d d%0d exp q1 r2 d3", lq, lr, ld); end
        repeat (3) @(negedge clk);
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", ovf); end
    endtask

    task automatic test_div_zero();
        issue(8'h00, 8'h55, 8'h00, 0);
        collect(qv, rv, ov, lq, lr, ld, nq);
        checks++; if (qv !== 8'hFF || rv !== 8'hFF || ov !== 1'b1 || lq !== 1) begin errors++; $display("FAIL divzero got %h/%h/%b/%0d exp ff/ff/1/1", qv, rv, ov, lq); end
    endtask

    task automatic test_strobe_order();
        @(negedge clk);
        start = 1'b1; divisor = 8'h0D;
        @(negedge clk);
        start = 1'b0; msb_in = 1'b1; data_in = 8'h99;
        @(negedge clk);
        lsb_in = 1'b1; msb_in = 1'b1; data_in = 8'h28;
        @(negedge clk);
        lsb_in = 1'b0; msb_in = 1'b0;
        @(negedge clk);
        msb_in = 1'b1; data_in = 8'h0A;
        @(negedge clk);
        msb_in = 1'b0;
        collect(qv, rv, ov, lq, lr, ld, nq);
        checks++; if (qv !== 8'hC8 || rv !== 8'h00) begin errors++; $display("FAIL strobe_order got %h/%h exp c8/00", qv, rv); end
        checks++; if (ov !== 1'b0 || lq !== 9) begin errors++; $display("FAIL strobe_order_lat got %b/%0d exp 0/9", ov, lq); end
    endtask

    task automatic test_start_in_iter();
        issue(8'h56, 8'h34, 8'h12, 0);
        @(posedge clk); @(posedge clk); @(posedge clk);
        @(negedge clk);
        start = 1'b1; divisor = 8'h03;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        collect(qv, rv, ov, lq, lr, ld, nq);
        checks++; if (qv !== 8'h36 || rv !== 8'h10) begin errors++; $display("FAIL start_iter got %h/%h exp 36/10", qv, rv); end
    endtask

    task automatic test_gap();
        issue(8'h56, 8'h34, 8'h12, 5);
        collect(qv, rv, ov, lq, lr, ld, nq);
        checks++; if (qv !== 8'h36 || rv !== 8'h10) begin errors++; $display("FAIL gap_qr got %h/%h exp 36/10", qv, rv); end
        checks++; if (lq !== 9 || lr !== 10) begin errors++; $display("FAIL gap_latency got q%0d r%0d exp q9 r10", lq, lr); end
    endtask

    task automatic test_mid_reset();
        issue(8'h0D, 8'h28, 8'h0A, 0);
        repeat (4) @(posedge clk);
        #3;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", done); end
        rst_n = 1'b0;
        #1;
        checks++; if (done !== 1'b1 || {q_valid, r_valid, ovf} !== 3'b000 || data_out !== 8'h00) begin
            errors++; $display("FAIL midrst_async got done%b flags%b data%h exp 1/000/00", done, {q_valid, r_valid, ovf}, data_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        issue(8'h0D, 8'h28, 8'h0A, 0);
        collect(qv, rv, ov, lq, lr, ld, nq);
        checks++; if (qv !== 8'hC8 || rv !== 8'h00 || ov !== 1'b0 || lq !== 9) begin errors++; $display("FAIL midrst_after got %h/%h/%b/%0d exp c8/00/0/9", qv, rv, ov, lq); end
    endtask

    initial begin
        test_reset();
        test_exact();
        test_remainder();
        test_max_operands();
        test_overflow();
        test_div_zero();
        test_strobe_order();
        test_start_in_iter();
        test_gap();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
